// File: rtl/motor_drive.sv
// Two-wheel H-bridge driver: tracker state -> per-wheel direction, ramped PWM duty, dead-time on reversal.
// Optional macro MOTOR_RAMP_EN enables the duty ramp (prescaled steps); without it duty jumps to its goal.
module motor_drive_wheel #(
    parameter int PWM_BITS    = 10,
    parameter int RAMP_STEP   = 16,
    parameter int DEAD_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                tgt_dir,
    input  logic [PWM_BITS-1:0] tgt_duty,
    output logic                pwm,
    output logic [1:0]          motor,
    output logic                busy
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} st_t;

    st_t                 st_q, st_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic                pwm_q, pwm_d;
    logic [1:0]          motor_q, motor_d;
    logic [PWM_BITS-1:0] run_next, dec_next;
    logic                decel_done;

`ifdef MOTOR_RAMP_EN
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

    function automatic logic [PWM_BITS-1:0] step_to(input logic [PWM_BITS-1:0] cur,
                                                    input logic [PWM_BITS-1:0] goal);
        if (goal > cur)
            step_to = (goal - cur > STEP) ? cur + STEP : goal;
        else
            step_to = (cur - goal > STEP) ? cur - STEP : goal;
    endfunction

    always_comb begin
        run_next   = step_to(duty_q, tgt_duty);
        dec_next   = step_to(duty_q, '0);
        decel_done = (duty_q == '0);
    end
`else
    // Without ramping the decel phase is a single cycle that drops duty to zero.
    always_comb begin
        run_next   = tgt_duty;
        dec_next   = '0;
        decel_done = 1'b1;
    end
`endif

    always_comb begin
        st_d   = st_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        dead_d = dead_q;
        unique case (st_q)
            IDLE: begin
                duty_d = '0;
                if (tgt_duty != '0) begin
                    dir_d = tgt_dir;
                    st_d  = RUN;
                end
            end
            RUN: begin
                if (tgt_duty != '0 && tgt_dir != dir_q)
                    st_d = DECEL;
                else if (duty_q == '0 && tgt_duty == '0)
                    st_d = IDLE;
                else if (tick)
                    duty_d = run_next;
            end
            DECEL: begin
                if (tgt_duty != '0 && tgt_dir == dir_q) begin
                    st_d = RUN;
                end else if (decel_done) begin
                    st_d   = DEAD;
                    duty_d = '0;
                    dead_d = DEAD_INIT;
                end else if (tick) begin
                    duty_d = dec_next;
                end
            end
            DEAD: begin
                // DEAD plus the following IDLE cycle together give DEAD_CYCLES of bridge-off.
                duty_d = '0;
                if (dead_q <= DW'(1)) begin
                    st_d   = IDLE;
                    dead_d = '0;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
        motor_d = (st_d == RUN || st_d == DECEL) ? (dir_d ? 2'b10 : 2'b01) : 2'b00;
        pwm_d   = (pwm_cnt < duty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= IDLE;
            dir_q   <= 1'b1;
            duty_q  <= '0;
            dead_q  <= '0;
            pwm_q   <= 1'b0;
            motor_q <= 2'b00;
        end else begin
            st_q    <= st_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
            motor_q <= motor_d;
        end
    end

    assign pwm   = pwm_q;
    assign motor = motor_q;
    assign busy  = (st_q != IDLE);
endmodule

module motor_drive #(
    parameter int PWM_BITS    = 10,
    parameter int FAST_DUTY   = 1000,
    parameter int SLOW_DUTY   = 600,
    parameter int RAMP_DIV    = 4096,
    parameter int RAMP_STEP   = 16,
    parameter int DEAD_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_move,
    input  logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_motor,
    output logic [1:0] right_motor,
    output logic       moving
);
    localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'(FAST_DUTY);
    localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'(SLOW_DUTY);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                tick;
    logic                l_dir, r_dir;
    logic [PWM_BITS-1:0] l_duty, r_duty;
    logic                l_busy, r_busy;

`ifdef MOTOR_RAMP_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [RW-1:0] ramp_q, ramp_d;

    always_comb begin
        tick   = (ramp_q == RW'(RAMP_DIV - 1));
        ramp_d = tick ? '0 : ramp_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ramp_q <= '0;
        else       ramp_q <= ramp_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Turning: the inner wheel reverses at reduced duty, the outer wheel stays fast forward.
    always_comb begin
        l_dir  = 1'b1;
        r_dir  = 1'b1;
        l_duty = '0;
        r_duty = '0;
        if (start_move) begin
            unique case (state)
                2'b11: begin
                    l_duty = FAST;
                    r_duty = FAST;
                end
                2'b10: begin
                    l_dir  = 1'b0;
                    l_duty = SLOW;
                    r_duty = FAST;
                end
                2'b01: begin
                    r_dir  = 1'b0;
                    r_duty = SLOW;
                    l_duty = FAST;
                end
                default: ;
            endcase
        end
    end

    motor_drive_wheel #(
        .PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_left (
        .clk(clk), .reset(reset), .tick(tick), .pwm_cnt(cnt_q),
        .tgt_dir(l_dir), .tgt_duty(l_duty),
        .pwm(left_pwm), .motor(left_motor), .busy(l_busy)
    );

    motor_drive_wheel #(
        .PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_right (
        .clk(clk), .reset(reset), .tick(tick), .pwm_cnt(cnt_q),
        .tgt_dir(r_dir), .tgt_duty(r_duty),
        .pwm(right_pwm), .motor(right_motor), .busy(r_busy)
    );

    assign moving = l_busy | r_busy;
endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with small parameters; expectations follow MOTOR_RAMP_EN.
module tb_motor_drive;
    logic       clk = 1'b0;
    logic       reset;
    logic       start_move;
    logic [1:0] state;
    logic       left_pwm, right_pwm, moving;
    logic [1:0] left_motor, right_motor;

    int checks = 0;
    int errors = 0;

    motor_drive #(
        .PWM_BITS(4), .FAST_DUTY(12), .SLOW_DUTY(6),
        .RAMP_DIV(2), .RAMP_STEP(4), .DEAD_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .start_move(start_move), .state(state),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_motor(left_motor), .right_motor(right_motor), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sm;
        logic [1:0] st;
        logic [1:0] lm;
        logic [1:0] rm;
        logic [3:0] ld;
        logic [3:0] rd;
        logic       mv;
    } vec_t;

    vec_t vt[6];

    logic [5:0] lh[$];
    logic [5:0] rh[$];
    logic [5:0] e[$];
    int l_off, l_rev, l_nf;
    logic [1:0] first_lm, first_rm;
    logic       first_mv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string fmt(input logic [5:0] q[$]);
        string s = "";
        foreach (q[i]) if (i < 12) s = {s, $sformatf("%b/%0d ", q[i][5:4], q[i][3:0])};
        return s;
    endfunction

    task automatic check_seq(input string name, input logic [5:0] got[$], input logic [5:0] exp[$]);
        bit ok;
        ok = (got.size() == exp.size());
        if (ok) foreach (exp[i]) if (got[i] != exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(got), fmt(exp));
        end
    endtask

    // Record {motor,duty} of each wheel per cycle, keeping only changes.
    task automatic trace(input int n);
        logic [5:0] ls, rs;
        lh.delete(); rh.delete();
        l_off = 0; l_rev = 0; l_nf = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ls = {left_motor, dut.u_left.duty_q};
            rs = {right_motor, dut.u_right.duty_q};
            if (i == 0) begin
                first_lm = left_motor;
                first_rm = right_motor;
                first_mv = moving;
            end
            if (lh.size() == 0 || lh[$] != ls) lh.push_back(ls);
            if (rh.size() == 0 || rh[$] != rs) rh.push_back(rs);
            if (left_motor == 2'b00) l_off++;
            if (left_motor == 2'b01) l_rev++;
            if (left_motor != 2'b10) l_nf++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pwm_count(input int n, output int lc, output int rc);
        lc = 0; rc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (left_pwm) lc++;
            if (right_pwm) rc++;
        end
    endtask

    initial begin
        int lc, rc, bad;
        bit found;

        vt[0] = '{1'b0, 2'b11, 2'b00, 2'b00, 4'd0,  4'd0,  1'b0};
        vt[1] = '{1'b1, 2'b00, 2'b00, 2'b00, 4'd0,  4'd0,  1'b0};
        vt[2] = '{1'b1, 2'b11, 2'b10, 2'b10, 4'd12, 4'd12, 1'b1};
        vt[3] = '{1'b1, 2'b10, 2'b01, 2'b10, 4'd6,  4'd12, 1'b1};
        vt[4] = '{1'b1, 2'b01, 2'b10, 2'b01, 4'd12, 4'd6,  1'b1};
        vt[5] = '{1'b0, 2'b10, 2'b00, 2'b00, 4'd0,  4'd0,  1'b0};

        // Reset held with start_move low
        reset = 1'b1; start_move = 1'b0; state = 2'b11;
        repeat (50) @(negedge clk);
        chk("rst_lmotor", left_motor, 0);
        chk("rst_rmotor", right_motor, 0);
        chk("rst_pwm", {left_pwm, right_pwm}, 0);
        chk("rst_moving", moving, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        pwm_count(16, lc, rc);
        chk("idle_pwm_low", lc + rc, 0);
        chk("idle_moving", moving, 0);

        // Start straight: motor on next cycle, duty ramps, 12/16 pwm
        start_move = 1'b1;
        trace(40);
        chk("start_lmotor", first_lm, 2);
        chk("start_rmotor", first_rm, 2);
        chk("start_moving", first_mv, 1);
        e.delete();
`ifdef MOTOR_RAMP_EN
        e.push_back(6'b10_0000); e.push_back(6'b10_0100);
        e.push_back(6'b10_1000); e.push_back(6'b10_1100);
`else
        e.push_back(6'b10_0000); e.push_back(6'b10_1100);
`endif
        check_seq("start_left_seq", lh, e);
        check_seq("start_right_seq", rh, e);
        pwm_count(16, lc, rc);
        chk("steady_lpwm", lc, 12);
        chk("steady_rpwm", rc, 12);

        // Target table from a fresh reset
        for (int i = 0; i < 6; i++) begin
            start_move = vt[i].sm;
            state = vt[i].st;
            do_reset();
            repeat (40) @(negedge clk);
            chk($sformatf("v%0d_lmotor", i), left_motor, vt[i].lm);
            chk($sformatf("v%0d_rmotor", i), right_motor, vt[i].rm);
            chk($sformatf("v%0d_lduty", i), dut.u_left.duty_q, vt[i].ld);
            chk($sformatf("v%0d_rduty", i), dut.u_right.duty_q, vt[i].rd);
            chk($sformatf("v%0d_moving", i), moving, vt[i].mv);
        end

        // Left reversal with dead-time
        start_move = 1'b1; state = 2'b11;
        do_reset();
        repeat (40) @(negedge clk);
        state = 2'b10;
        trace(80);
        e.delete();
`ifdef MOTOR_RAMP_EN
        e.push_back(6'b10_1100); e.push_back(6'b10_1000); e.push_back(6'b10_0100);
        e.push_back(6'b10_0000); e.push_back(6'b00_0000); e.push_back(6'b01_0000);
        e.push_back(6'b01_0100); e.push_back(6'b01_0110);
`else
        e.push_back(6'b10_1100); e.push_back(6'b00_0000);
        e.push_back(6'b01_0000); e.push_back(6'b01_0110);
`endif
        check_seq("rev_left_seq", lh, e);
        chk("rev_dead_cycles", l_off, 5);
        e.delete();
        e.push_back(6'b10_1100);
        check_seq("rev_right_seq", rh, e);

        // Return to straight in the middle of decel
        state = 2'b11;
        do_reset();
        repeat (40) @(negedge clk);
        state = 2'b10;
        bad = 0;
`ifdef MOTOR_RAMP_EN
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (left_motor != 2'b10) bad++;
            if (dut.u_left.duty_q == 4'd8) found = 1;
        end
        chk("abort_saw_duty8", found, 1);
`else
        @(negedge clk);
        if (left_motor != 2'b10) bad++;
`endif
        state = 2'b11;
        trace(40);
        chk("abort_motor_stays_fwd", bad + l_nf, 0);
        chk("abort_final_duty", dut.u_left.duty_q, 12);

        // Stop during decel: no reverse drive, both wheels end idle
        state = 2'b10;
        @(negedge clk);
        state = 2'b00;
        trace(60);
        chk("stop_no_reverse", l_rev, 0);
        chk("stop_lmotor", left_motor, 0);
        chk("stop_moving", moving, 0);

        // Asynchronous reset while running
        state = 2'b11;
        repeat (40) @(negedge clk);
        chk("pre_rst_lmotor", left_motor, 2);
        reset = 1'b1;
        #1;
        chk("async_motors", {left_motor, right_motor}, 0);
        chk("async_pwm", {left_pwm, right_pwm}, 0);
        chk("async_duty", {dut.u_left.duty_q, dut.u_right.duty_q}, 0);
        @(negedge clk);
        reset = 1'b0;
        trace(30);
        e.delete();
`ifdef MOTOR_RAMP_EN
        e.push_back(6'b10_0000); e.push_back(6'b10_0100);
        e.push_back(6'b10_1000); e.push_back(6'b10_1100);
`else
        e.push_back(6'b10_0000); e.push_back(6'b10_1100);
`endif
        check_seq("post_rst_left_seq", lh, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
